// File: rtl/reg_file_onehot.sv
// reg_file_onehot: register file addressed by one-hot selects.
// Two registered read ports with write-to-read bypass, one write port,
// a sequential bulk-clear engine and a sticky error flag for any used
// select that is not exactly one-hot.
// Optional build macro: R0_ZERO_EN -- when defined, register 0 reads as
// zero and writes to it are discarded without raising sel_err.
module reg_file_onehot #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [NREGS-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NREGS-1:0]  rd_sel_a,
    input  logic [NREGS-1:0]  rd_sel_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              sel_err
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  cnt_next;
    logic [DATA_W-1:0] regs [NREGS];

    logic              wr_onehot;
    logic              rd_onehot_a;
    logic              rd_onehot_b;
    logic              wr_valid;
    logic              wr_commit;
    logic              wr_err;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx_a;
    logic [IDX_W-1:0]  rd_idx_b;
    logic [DATA_W-1:0] rd_next_a;
    logic [DATA_W-1:0] rd_next_b;

    // True when exactly one bit is set; all-zero counts as invalid.
    function automatic logic is_onehot(input logic [NREGS-1:0] v);
        return (v != '0) && ((v & (v - NREGS'(1))) == '0);
    endfunction

    // Binary index of the set bit; only meaningful for one-hot input.
    function automatic logic [IDX_W-1:0] encode(input logic [NREGS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign wr_onehot   = is_onehot(wr_sel);
    assign rd_onehot_a = is_onehot(rd_sel_a);
    assign rd_onehot_b = is_onehot(rd_sel_b);
    assign wr_idx      = encode(wr_sel);
    assign rd_idx_a    = encode(rd_sel_a);
    assign rd_idx_b    = encode(rd_sel_b);

    // Writes are only honoured while idle; during a clear they vanish
    // without being error-checked.
    assign wr_valid = wr_en && (state == IDLE) && wr_onehot;
    assign wr_err   = wr_en && (state == IDLE) && !wr_onehot;

`ifdef R0_ZERO_EN
    assign wr_commit = wr_valid && (wr_idx != '0);
`else
    assign wr_commit = wr_valid;
`endif

    assign busy = (state == CLEAR);

    // Next read data for both ports: zero on a bad select, bypassed write
    // data on an index match, otherwise the stored contents.
    always_comb begin
        rd_next_a = '0;
        rd_next_b = '0;
        if (rd_onehot_a) begin
            if (wr_commit && (wr_idx == rd_idx_a)) begin
                rd_next_a = wr_data;
            end else begin
                rd_next_a = regs[rd_idx_a];
            end
`ifdef R0_ZERO_EN
            if (rd_idx_a == '0) begin
                rd_next_a = '0;
            end
`endif
        end
        if (rd_onehot_b) begin
            if (wr_commit && (wr_idx == rd_idx_b)) begin
                rd_next_b = wr_data;
            end else begin
                rd_next_b = regs[rd_idx_b];
            end
`ifdef R0_ZERO_EN
            if (rd_idx_b == '0) begin
                rd_next_b = '0;
            end
`endif
        end
    end

    // Clear-engine sequencing: one register zeroed per cycle, NREGS cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any clear in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Register array: the clear engine has priority, otherwise a valid write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_commit) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Registered read ports, one cycle after the select is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= rd_next_a;
            rd_data_b <= rd_next_b;
        end
    end

    // Sticky select-error flag, only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (wr_err || !rd_onehot_a || !rd_onehot_b) begin
            sel_err <= 1'b1;
        end
    end

endmodule
